// File: rtl/seq_div_unit.sv
// ============================================================================
// Module   : seq_div_unit
// Brief    : Multi-cycle radix-2 restoring divider (DIV/DIVU), Hi=rem, Lo=quo.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic             sign,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             valid_out,
    output logic             div_zero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] araw_q, araw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             divz_q, divz_d;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;

    assign w_abs_a = (sign && SrcA[WIDTH-1]) ? -SrcA : SrcA;
    assign w_abs_b = (sign && SrcB[WIDTH-1]) ? -SrcB : SrcB;

    // The stored remainder is always below the divisor, so WIDTH bits hold it;
    // only the shifted trial value needs the extra bit.
    assign w_shift = {rem_q, quo_q[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, dvsr_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            araw_q  <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            divz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            araw_q  <= araw_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            divz_q  <= divz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        araw_d  = araw_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        divz_d  = divz_q;

        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    negq_d  = sign & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                    negr_d  = sign & SrcA[WIDTH-1];
                    dz_d    = (SrcB == '0);
                    araw_d  = SrcA;
                    dvsr_d  = w_abs_b;
                    quo_d   = w_abs_a;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                rem_d = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ~w_diff[WIDTH]};
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIX: begin
                // A zero divisor reports the raw dividend with no sign fix-up.
                if (dz_q) begin
                    lo_d = '1;
                    hi_d = araw_q;
                end else begin
                    lo_d = negq_q ? -quo_q : quo_q;
                    hi_d = negr_q ? -rem_q : rem_q;
                end
                divz_d  = dz_q;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
    assign valid_out = (state_q == S_DONE);
    assign div_zero  = divz_q;
    assign Hi        = hi_q;
    assign Lo        = lo_q;

endmodule

`default_nettype wire

// File: doc/seq_div_unit.md
Name: seq_div_unit

Overview:
- Multi-cycle radix-2 restoring divider that executes DIV and DIVU for the execute-stage ALU wrapper.
- Produces Hi (remainder) and Lo (quotient), which the wrapper writes into its Hi/Lo registers.
- The wrapper holds valid_in high and stalls the pipeline until valid_out is seen.
- Fixed latency, one operation in flight.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- valid_in  input  1  request; sampled only in IDLE.
- sign  input  1  1 = signed (DIV), 0 = unsigned (DIVU); captured with operands.
- SrcA  input  WIDTH  dividend; captured when valid_in accepted.
- SrcB  input  WIDTH  divisor; captured when valid_in accepted.
- busy  output  1  high in CALC and FIX.
- valid_out  output  1  one-cycle pulse: Hi/Lo hold a new result.
- div_zero  output  1  qualifies the current result; 1 if the divisor was 0.
- Hi  output  WIDTH  remainder.
- Lo  output  WIDTH  quotient.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state = IDLE; busy, valid_out, div_zero = 0; Hi, Lo = 0; internal registers cleared.
  - An in-flight operation is discarded and never produces valid_out.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - If valid_in = 1 at a rising edge, capture sign, SrcA and SrcB.
  - Form magnitudes: if sign = 1 and an operand is negative, use its two's complement, else the raw value.
  - Record neg_q = sign & (A[MSB] ^ B[MSB]) and neg_r = sign & A[MSB].
  - Clear the WIDTH+1-bit partial remainder; load the quotient register with |A|; counter = 0; go to CALC.
- CALC, one quotient bit per cycle for WIDTH cycles:
  - Shift {rem, quo} left by 1.
  - Trial subtract |B| from the WIDTH+1-bit rem.
  - If the result is non-negative, rem = difference and quo[0] = 1; else rem is unchanged and quo[0] = 0.
  - When counter = WIDTH-1, go to FIX; else counter + 1.
- FIX:
  - Lo <= neg_q ? -quo : quo.
  - Hi <= neg_r ? -rem : rem.
  - Go to DONE.
- DONE:
  - valid_out = 1 for exactly this cycle; Hi/Lo are valid.
  - Go to IDLE on the next edge.
- Hi, Lo and div_zero hold their values until the next FIX or reset.
- Latency: valid_in accepted at edge 0; CALC spans edges 1..WIDTH; FIX result is registered at edge WIDTH+1; valid_out is high between edges WIDTH+1 and WIDTH+2 (cycles 33-34 for WIDTH = 32).
- Back-to-back: IDLE occupies one cycle after DONE. If valid_in is still high at that edge, a new operation starts with the operands present then; the wrapper must drop valid_in on valid_out.
- valid_in is ignored while busy or in DONE; SrcA/SrcB changes after capture have no effect.
- Divide by zero:
  - Same latency.
  - Lo = all ones, Hi = SrcA as captured (raw, no sign fix), div_zero = 1 during and after DONE.
  - Sign fix-up is suppressed.
  - div_zero is cleared by the next non-zero-divisor result.
- Signed overflow (most-negative / -1): Lo = 0x80000000, Hi = 0; no flag.
- Signed results follow truncation toward zero: remainder takes the dividend's sign and |Hi| < |B|.
- Arithmetic: magnitudes are unsigned WIDTH bits (|0x80000000| = 0x80000000); the trial subtract is WIDTH+1 bits wide; no other state.

Test Plan:
- Unsigned: sign=0, A=100, B=7 -> after 34 cycles valid_out pulse, Lo=14, Hi=2, div_zero=0, busy low in DONE.
- Signed mixed: sign=1, A=-7 (0xFFFFFFF9), B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1); then A=7, B=-2 -> Lo=-3, Hi=1.
- Edge values:
  - sign=0, A=0xFFFFFFFF, B=1 -> Lo=0xFFFFFFFF, Hi=0.
  - sign=1, A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
  - sign=0, A=5, B=9 -> Lo=0, Hi=5.
- Divide by zero: sign=1, A=0x12345678, B=0 -> Lo=0xFFFFFFFF, Hi=0x12345678, div_zero=1; a following 10/3 op clears div_zero (Lo=3, Hi=1).
- Handshake:
  - Hold valid_in high continuously -> valid_out pulses every 35 cycles, each single-cycle.
  - Change SrcA/SrcB mid-CALC -> result unaffected.
  - valid_in pulsed during busy -> ignored.
- Reset mid-CALC (cycle 10) -> all outputs 0 immediately (asynchronous), no valid_out; a new op after reset release completes normally with correct latency.
